// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: bit-serial N-bit unsigned adder with a start/done handshake.
// One full-adder cell processes one bit per clock, LSB first. The result
// registers update only when the last bit has been processed, so no partial
// sum is ever visible on the outputs.
module serial_adder_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int CNT_W = $clog2(NUM_BITS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [NUM_BITS-1:0] a_q,     a_d;
    logic [NUM_BITS-1:0] b_q,     b_d;
    logic                c_q,     c_d;
    logic [NUM_BITS-1:0] res_q,   res_d;
    logic [NUM_BITS-1:0] sum_q,   sum_d;
    logic                ovf_q,   ovf_d;

    // Single full-adder cell working on the current LSB of the operand shifters.
    logic bit_sum;
    logic bit_carry;
    assign bit_sum   = a_q[0] ^ b_q[0] ^ c_q;
    assign bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    // Next-state logic: capture operands in IDLE, shift one bit per ADD cycle,
    // publish the result on the last ADD cycle, then return to IDLE via DONE.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path can leave it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                res_d = {bit_sum, res_q[NUM_BITS-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = bit_carry;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {bit_sum, res_q[NUM_BITS-1:1]};
                    ovf_d   = bit_carry;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset; reset overrides start.
    always_ff @(posedge clk) begin
        // NOTE: the datapath shifters are reset too, so an aborted operation leaves no stale bits behind.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_ADD) || (state_q == ST_DONE);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: directed checks of the bit-serial adder at NUM_BITS=4
// (table vectors, handshake and reset corner cases, all 512 operand combos)
// plus one NUM_BITS=8 instance for the wide carry-ripple case.
module tb_serial_adder_nbit;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       ovf4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       ovf8;

    int total;
    int bad;

    logic [3:0] prev_sum;
    logic       prev_ovf;

    serial_adder_nbit #(.NUM_BITS(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .start    (start4),
        .a        (a4),
        .b        (b4),
        .carry_in (cin4),
        .busy     (busy4),
        .done     (done4),
        .sum      (sum4),
        .overflow (ovf4)
    );

    serial_adder_nbit #(.NUM_BITS(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
        .a        (a8),
        .b        (b8),
        .carry_in (cin8),
        .busy     (busy8),
        .done     (done8),
        .sum      (sum8),
        .overflow (ovf8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full 4-bit operation started from IDLE. Observations are taken just
    // after edges E0..E5; done must be seen only after E4 (sampled at E5).
    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tbv,
                          input logic tc, input logic [3:0] es, input logic eo);
        a4 = ta; b4 = tbv; cin4 = tc; start4 = 1'b1;
        step();
        start4 = 1'b0; a4 = ~ta; b4 = ~tbv; cin4 = ~tc;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_busy_mid"}, 32'(busy4), 32'd1);
            check({tag, "_done_early"}, 32'(done4), 32'd0);
            check({tag, "_sum_held"}, 32'(sum4), 32'(prev_sum));
            check({tag, "_ovf_held"}, 32'(ovf4), 32'(prev_ovf));
            step();
        end
        check({tag, "_done"}, 32'(done4), 32'd1);
        check({tag, "_busy_done"}, 32'(busy4), 32'd1);
        check({tag, "_sum"}, 32'(sum4), 32'(es));
        check({tag, "_ovf"}, 32'(ovf4), 32'(eo));
        prev_sum = es;
        prev_ovf = eo;
        step();
        check({tag, "_done_pulse_end"}, 32'(done4), 32'd0);
        check({tag, "_busy_end"}, 32'(busy4), 32'd0);
        check({tag, "_sum_after"}, 32'(sum4), 32'(es));
        check({tag, "_ovf_after"}, 32'(ovf4), 32'(eo));
    endtask

    initial begin
        logic [4:0] full;
        int         bad_before;
        int         pass_ops;

        total = 0;
        bad   = 0;

        vecs[0] = '{4'h4, 4'h5, 1'b0, 4'h9, 1'b0};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[4] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0};
        vecs[5] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1};
        vecs[7] = '{4'h3, 4'h6, 1'b1, 4'hA, 1'b0};
        vecs[8] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0};

        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_busy", 32'(busy4), 32'd0);
        check("reset_done", 32'(done4), 32'd0);
        check("reset_sum", 32'(sum4), 32'd0);
        check("reset_ovf", 32'(ovf4), 32'd0);
        check("reset8_busy", 32'(busy8), 32'd0);
        check("reset8_sum", 32'(sum8), 32'd0);
        prev_sum = 4'h0;
        prev_ovf = 1'b0;

        // Start stays low: the adder must remain idle.
        step();
        check("idle_no_start", 32'(busy4), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].ovf);
        end

        // Start held high with operands changing during ADD: one result, one
        // done pulse, and the second request is accepted only at E6.
        a4 = 4'h2; b4 = 4'h9; cin4 = 1'b0; start4 = 1'b1;
        step();
        a4 = 4'h3; b4 = 4'h3;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("hold_done_early", 32'(done4), 32'd0);
        end
        step();
        check("hold_done", 32'(done4), 32'd1);
        check("hold_sum", 32'(sum4), 32'hB);
        check("hold_ovf", 32'(ovf4), 32'd0);
        step();
        check("hold_idle_busy", 32'(busy4), 32'd0);
        check("hold_idle_done", 32'(done4), 32'd0);
        check("hold_idle_sum", 32'(sum4), 32'hB);
        step();
        check("hold_accept_e6", 32'(busy4), 32'd1);
        check("hold_accept_done", 32'(done4), 32'd0);
        start4 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check("hold2_done_early", 32'(done4), 32'd0);
            check("hold2_sum_held", 32'(sum4), 32'hB);
        end
        step();
        check("hold2_done", 32'(done4), 32'd1);
        check("hold2_sum", 32'(sum4), 32'h6);
        check("hold2_ovf", 32'(ovf4), 32'd0);
        step();
        check("hold2_end", 32'(done4), 32'd0);
        prev_sum = 4'h6;
        prev_ovf = 1'b0;

        // Reset at E2 of an operation aborts it with no done pulse.
        a4 = 4'h4; b4 = 4'h5; cin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_done", 32'(done4), 32'd0);
        check("abort_sum", 32'(sum4), 32'd0);
        check("abort_ovf", 32'(ovf4), 32'd0);
        prev_sum = 4'h0;
        prev_ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_done", 32'(done4), 32'd0);
            check("abort_stay_idle", 32'(busy4), 32'd0);
        end
        run_op("after_abort", 4'h7, 4'h8, 1'b0, 4'hF, 1'b0);

        // Reset and start on the same edge: reset wins, start dropped.
        rst = 1'b1; start4 = 1'b1; a4 = 4'h1; b4 = 4'h1;
        step();
        rst = 1'b0; start4 = 1'b0;
        check("rst_start_busy", 32'(busy4), 32'd0);
        check("rst_start_sum", 32'(sum4), 32'd0);
        step();
        check("rst_start_still_idle", 32'(busy4), 32'd0);
        check("rst_start_no_done", 32'(done4), 32'd0);
        prev_sum = 4'h0;
        prev_ovf = 1'b0;

        // Every {cin,b,a} combination against a plain 5-bit addition.
        pass_ops = 0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            idx  = 9'(i);
            full = 5'(idx[3:0]) + 5'(idx[7:4]) + 5'(idx[8]);
            bad_before = bad;
            run_op("exh", idx[3:0], idx[7:4], idx[8], full[3:0], full[4]);
            if (bad == bad_before) pass_ops++;
        end
        $display("exhaustive: %0d of 512 combos correct", pass_ops);

        // NUM_BITS=8: carry ripples through all eight bits; done seen after E8.
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
        step();
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        check("w8_busy_e0", 32'(busy8), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check("w8_done_early", 32'(done8), 32'd0);
            check("w8_sum_held", 32'(sum8), 32'd0);
        end
        step();
        check("w8_done", 32'(done8), 32'd1);
        check("w8_sum", 32'(sum8), 32'h01);
        check("w8_ovf", 32'(ovf8), 32'd1);
        step();
        check("w8_done_end", 32'(done8), 32'd0);
        check("w8_busy_end", 32'(busy8), 32'd0);
        check("w8_sum_after", 32'(sum8), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
